cpu_control_fsm: RTL and testbench

Multi-cycle sequencer for the SCC core. It drives instruction fetch, latches the instruction class produced by the instruction decoder, and issues the enables for the ALU flags, data memory, register file and PC in the correct order, one instruction at a time. It also adds a memory-handshake watchdog, halt detection and a retired-instruction counter. It sits between the instruction/data memory interfaces and the decode/ALU/register-file datapath.

---
 rtl/cpu_control_fsm_if.sv | 25 ++
 rtl/cpu_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Memory handshake bundle between the SCC control sequencer and the
// instruction/data memory ports.
interface cpu_control_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle sequencer for the SCC core: fetch, decode, execute, memory and
// write-back enables, with a memory watchdog, halt detection and retire count.
module cpu_control_fsm #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  cpu_control_fsm_if.master mem,
  output logic              o_ir_load,
  input  logic              i_dec_branch,
  input  logic              i_dec_load_store,
  input  logic              i_dec_data_reg,
  input  logic              i_dec_data_imm,
  input  logic              i_dec_special,
  input  logic              i_dec_set_flags,
  input  logic              i_dec_halt,
  input  logic              i_branch_taken,
  output logic              o_rf_we,
  output logic              o_flags_we,
  output logic              o_pc_en,
  output logic              o_pc_branch_sel,
  output logic [2:0]        o_state,
  output logic              o_halted,
  output logic              o_fault,
  output logic [31:0]       o_retired_count
);

  localparam int unsigned WAIT_W = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned CLS_W  = 4;
  localparam int unsigned CLS_BR = 3;
  localparam int unsigned CLS_LS = 2;
  localparam int unsigned CLS_DR = 1;
  localparam int unsigned CLS_DI = 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_next;
  logic [CLS_W-1:0]    r_cls;
  logic [CLS_W-1:0]    w_cls;
  logic                r_special;
  logic                r_set_flags;
  logic                r_halted;
  logic                r_fault;
  logic [CNT_W-1:0]    r_retired;
  logic                w_imem_req;
  logic                w_dmem_req;
  logic                w_dmem_we;

  assign w_cls = {i_dec_branch, i_dec_load_store, i_dec_data_reg, i_dec_data_imm};

  // State register and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
    end
  end

  // Next state and strobes; the wait counter resets on any transition or ack
  always_comb begin
    w_next          = r_state;
    w_wait_next     = '0;
    w_imem_req      = 1'b0;
    w_dmem_req      = 1'b0;
    w_dmem_we       = 1'b0;
    o_ir_load       = 1'b0;
    o_rf_we         = 1'b0;
    o_flags_we      = 1'b0;
    o_pc_en         = 1'b0;
    o_pc_branch_sel = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (mem.imem_ack) begin
          o_ir_load = 1'b1;
          w_next    = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_next = S_FAULT;
        end else begin
          w_wait_next = r_wait + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (i_dec_halt)          w_next = S_HALT;
        else if (!$onehot(w_cls)) w_next = S_FAULT;
        else                     w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        o_flags_we = r_set_flags & (r_cls[CLS_DR] | r_cls[CLS_DI]);
        if (r_cls[CLS_BR]) begin
          o_pc_en         = 1'b1;
          o_pc_branch_sel = i_branch_taken;
          w_next          = S_FETCH;
        end else if (r_cls[CLS_LS]) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = r_special;
        if (mem.dmem_ack) begin
          o_pc_en = r_special;
          w_next  = r_special ? S_FETCH : S_WB;
        end else if (r_wait == WAIT_LAST) begin
          w_next = S_FAULT;
        end else begin
          w_wait_next = r_wait + WAIT_W'(1);
        end
      end
      S_WB: begin
        o_rf_we = 1'b1;
        o_pc_en = 1'b1;
        w_next  = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  // Decoded instruction attributes, sticky status and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls       <= '0;
      r_special   <= 1'b0;
      r_set_flags <= 1'b0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
      r_retired   <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_cls       <= w_cls;
        r_special   <= i_dec_special;
        r_set_flags <= i_dec_set_flags;
      end
      r_halted <= r_halted | (w_next == S_HALT);
      r_fault  <= r_fault | (w_next == S_FAULT);
      if (o_pc_en) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign mem.imem_req    = w_imem_req;
  assign mem.dmem_req    = w_dmem_req;
  assign mem.dmem_we     = w_dmem_we;
  assign o_state         = r_state;
  assign o_halted        = r_halted;
  assign o_fault         = r_fault;
  assign o_retired_count = r_retired;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm (TIMEOUT = 4): each step sets inputs on
// the falling edge and checks the full output vector 1 ns later.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_load, rf_we, flags_we, pc_en, pc_branch_sel, halted, fault;
  logic [2:0]  state;
  logic [31:0] retired_count;
  logic        dec_branch, dec_load_store, dec_data_reg, dec_data_imm;
  logic        dec_special, dec_set_flags, dec_halt, branch_taken;
  int          n_cmp = 0;
  int          n_err = 0;

  cpu_control_fsm_if mif ();

  cpu_control_fsm #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem             (mif),
    .o_ir_load       (ir_load),
    .i_dec_branch    (dec_branch),
    .i_dec_load_store(dec_load_store),
    .i_dec_data_reg  (dec_data_reg),
    .i_dec_data_imm  (dec_data_imm),
    .i_dec_special   (dec_special),
    .i_dec_set_flags (dec_set_flags),
    .i_dec_halt      (dec_halt),
    .i_branch_taken  (branch_taken),
    .o_rf_we         (rf_we),
    .o_flags_we      (flags_we),
    .o_pc_en         (pc_en),
    .o_pc_branch_sel (pc_branch_sel),
    .o_state         (state),
    .o_halted        (halted),
    .o_fault         (fault),
    .o_retired_count (retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "bench time limit expired");
  end

  // {imem_req, ir_load, dmem_req, dmem_we, rf_we, flags_we, pc_en, pc_sel, halted, fault, state}
  function automatic logic [12:0] e(input logic ireq, il, dreq, dwe, rw, fw, pe, ps, h, f,
                                    input logic [2:0] st);
    return {ireq, il, dreq, dwe, rw, fw, pe, ps, h, f, st};
  endfunction

  task automatic cyc(input string tag, input logic [12:0] exp, input logic [31:0] exp_ret);
    logic [12:0] obs;
    #1;
    obs = {mif.imem_req, ir_load, mif.dmem_req, mif.dmem_we, rf_we, flags_we,
           pc_en, pc_branch_sel, halted, fault, state};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs, exp);
    end
    n_cmp++;
    assert (retired_count === exp_ret) else begin
      n_err++;
      $error("FAIL %s retired: observed %0d expected %0d", tag, retired_count, exp_ret);
    end
    @(negedge clk);
  endtask

  task automatic set_dec(input logic br, ls, dr, di, sp, sf, hl, bt);
    dec_branch = br; dec_load_store = ls; dec_data_reg = dr; dec_data_imm = di;
    dec_special = sp; dec_set_flags = sf; dec_halt = hl; branch_taken = bt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc("reset", e(1,0,0,0,0,0,0,0,0,0,3'd0), 0);

    // data-immediate with set_flags, acks tied high
    set_dec(0, 0, 0, 1, 0, 1, 0, 0);
    mif.imem_ack = 1'b1;
    mif.dmem_ack = 1'b1;
    cyc("dimm_fetch", e(1,1,0,0,0,0,0,0,0,0,3'd0), 0);
    cyc("dimm_decode", e(0,0,0,0,0,0,0,0,0,0,3'd1), 0);
    cyc("dimm_exec", e(0,0,0,0,0,1,0,0,0,0,3'd2), 0);
    cyc("dimm_wb", e(0,0,0,0,1,0,1,0,0,0,3'd4), 0);
    mif.imem_ack = 1'b0;
    cyc("dimm_next", e(1,0,0,0,0,0,0,0,0,0,3'd0), 1);

    // load, dmem_ack on the 4th MEM cycle (last watchdog cycle: ack wins)
    set_dec(0, 1, 0, 0, 0, 1, 0, 0);
    mif.imem_ack = 1'b1;
    mif.dmem_ack = 1'b0;
    cyc("ld_fetch", e(1,1,0,0,0,0,0,0,0,0,3'd0), 1);
    cyc("ld_decode", e(0,0,0,0,0,0,0,0,0,0,3'd1), 1);
    cyc("ld_exec", e(0,0,0,0,0,0,0,0,0,0,3'd2), 1);
    cyc("ld_mem0", e(0,0,1,0,0,0,0,0,0,0,3'd3), 1);
    cyc("ld_mem1", e(0,0,1,0,0,0,0,0,0,0,3'd3), 1);
    cyc("ld_mem2", e(0,0,1,0,0,0,0,0,0,0,3'd3), 1);
    mif.dmem_ack = 1'b1;
    cyc("ld_mem3_ack", e(0,0,1,0,0,0,0,0,0,0,3'd3), 1);
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    cyc("ld_wb", e(0,0,0,0,1,0,1,0,0,0,3'd4), 1);
    cyc("ld_next", e(1,0,0,0,0,0,0,0,0,0,3'd0), 2);

    // store followed by taken branch
    set_dec(0, 1, 0, 0, 1, 0, 0, 0);
    mif.imem_ack = 1'b1;
    mif.dmem_ack = 1'b1;
    cyc("st_fetch", e(1,1,0,0,0,0,0,0,0,0,3'd0), 2);
    cyc("st_decode", e(0,0,0,0,0,0,0,0,0,0,3'd1), 2);
    cyc("st_exec", e(0,0,0,0,0,0,0,0,0,0,3'd2), 2);
    cyc("st_mem_ack", e(0,0,1,1,0,0,1,0,0,0,3'd3), 2);
    set_dec(1, 0, 0, 0, 0, 0, 0, 1);
    cyc("br_fetch", e(1,1,0,0,0,0,0,0,0,0,3'd0), 3);
    cyc("br_decode", e(0,0,0,0,0,0,0,0,0,0,3'd1), 3);
    cyc("br_exec", e(0,0,0,0,0,0,1,1,0,0,3'd2), 3);
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    cyc("br_next", e(1,0,0,0,0,0,0,0,0,0,3'd0), 4);

    // fetch timeout: request held exactly 4 cycles, then FAULT
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc("to_wait", e(1,0,0,0,0,0,0,0,0,0,3'd0), 0);
    cyc("to_fault", e(0,0,0,0,0,0,0,0,0,1,3'd6), 0);
    cyc("to_fault_hold", e(0,0,0,0,0,0,0,0,0,1,3'd6), 0);

    // ack in the final timeout cycle, then a halt instruction
    do_reset();
    set_dec(0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      cyc("late_wait", e(1,0,0,0,0,0,0,0,0,0,3'd0), 0);
    mif.imem_ack = 1'b1;
    cyc("late_ack", e(1,1,0,0,0,0,0,0,0,0,3'd0), 0);
    cyc("late_decode", e(0,0,0,0,0,0,0,0,0,0,3'd1), 0);
    for (int i = 0; i < 20; i++)
      cyc("halt_hold", e(0,0,0,0,0,0,0,0,1,0,3'd5), 0);
    mif.imem_ack = 1'b0;
    do_reset();
    cyc("halt_reset", e(1,0,0,0,0,0,0,0,0,0,3'd0), 0);

    // non-one-hot class (data_reg + branch) faults from DECODE
    do_reset();
    set_dec(1, 0, 1, 0, 0, 0, 0, 0);
    mif.imem_ack = 1'b1;
    cyc("bad_fetch", e(1,1,0,0,0,0,0,0,0,0,3'd0), 0);
    cyc("bad_decode", e(0,0,0,0,0,0,0,0,0,0,3'd1), 0);
    cyc("bad_fault", e(0,0,0,0,0,0,0,0,0,1,3'd6), 0);

    // untaken branch, then reset during a stalled load MEM cycle
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 0, 0);
    cyc("rb_fetch", e(1,1,0,0,0,0,0,0,0,0,3'd0), 0);
    cyc("rb_decode", e(0,0,0,0,0,0,0,0,0,0,3'd1), 0);
    set_dec(0, 1, 0, 0, 0, 0, 0, 0);
    cyc("rb_exec", e(0,0,0,0,0,0,1,0,0,0,3'd2), 0);
    cyc("rl_fetch", e(1,1,0,0,0,0,0,0,0,0,3'd0), 1);
    mif.imem_ack = 1'b0;
    cyc("rl_decode", e(0,0,0,0,0,0,0,0,0,0,3'd1), 1);
    cyc("rl_exec", e(0,0,0,0,0,0,0,0,0,0,3'd2), 1);
    cyc("rl_mem0", e(0,0,1,0,0,0,0,0,0,0,3'd3), 1);
    cyc("rl_mem1", e(0,0,1,0,0,0,0,0,0,0,3'd3), 1);
    do_reset();
    cyc("rl_reset", e(1,0,0,0,0,0,0,0,0,0,3'd0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
